// File: rtl/muldiv_unit.sv
// Iterative signed multiply / divide unit.
// Multiply uses shift-add over the operand magnitudes. Divide uses a restoring
// shift-subtract over the magnitudes. A single FIX cycle at the end applies the
// sign correction.
module muldiv_unit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] data_1,
   input  logic [WIDTH-1:0] data_2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned PW    = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             state_q, state_d;

   // Operation context captured at the accepting edge
   logic               op_q, op_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic               dz_q, dz_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Iteration registers: acc is the product high half / partial remainder,
   // lo is the multiplier / dividend being shifted out, opnd the fixed operand
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;

   logic               busy_d, done_d, div_by_zero_d;
   logic [WIDTH-1:0]   result_lo_d, result_hi_d;

   logic               accept_c;
   logic               zero_div_c;
   logic               last_iter_c;
   logic [WIDTH-1:0]   mag_1_c, mag_2_c;
   logic [WIDTH:0]     mul_sum_c;
   logic [WIDTH:0]     div_shift_c;
   logic [WIDTH:0]     div_trial_c;
   logic [PW-1:0]      prod_mag_c, prod_c;
   logic [WIDTH-1:0]   quo_c, rem_c, dividend_c;

   // Operand magnitudes. The most negative value maps onto itself, which is
   // the correct unsigned magnitude.
   assign mag_1_c     = data_1[WIDTH-1] ? -data_1 : data_1;
   assign mag_2_c     = data_2[WIDTH-1] ? -data_2 : data_2;

   assign accept_c    = (state_q == IDLE) && start;
   assign zero_div_c  = op && (data_2 == '0);
   assign last_iter_c = (cnt_q == CNT_W'(WIDTH - 1));

   // One shift-add step: add the multiplicand when the multiplier LSB is set
   assign mul_sum_c   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

   // One restoring step: bring in the next dividend bit and try to subtract
   assign div_shift_c = {acc_q, lo_q[WIDTH-1]};
   assign div_trial_c = div_shift_c - {1'b0, opnd_q};

   // Sign correction applied in FIX
   assign prod_mag_c  = {acc_q, lo_q};
   assign prod_c      = (sign_a_q ^ sign_b_q) ? -prod_mag_c : prod_mag_c;
   assign quo_c       = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
   assign rem_c       = sign_a_q ? -acc_q : acc_q;
   assign dividend_c  = sign_a_q ? -lo_q : lo_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a divide by zero jumps straight to FIX
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = zero_div_c ? FIX : CALC;
            end
         end
         CALC: begin
            if (last_iter_c) begin
               state_d = FIX;
            end
         end
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      op_d          = op_q;
      sign_a_d      = sign_a_q;
      sign_b_d      = sign_b_q;
      dz_d          = dz_q;
      cnt_d         = cnt_q;
      acc_d         = acc_q;
      lo_d          = lo_q;
      opnd_d        = opnd_q;
      busy_d        = busy;
      done_d        = 1'b0;
      div_by_zero_d = div_by_zero;
      result_lo_d   = result_lo;
      result_hi_d   = result_hi;

      case (state_q)
         IDLE: begin
            if (accept_c) begin
               op_d     = op;
               sign_a_d = data_1[WIDTH-1];
               sign_b_d = data_2[WIDTH-1];
               dz_d     = zero_div_c;
               cnt_d    = '0;
               acc_d    = '0;
               busy_d   = 1'b1;
               if (op) begin
                  lo_d   = mag_1_c;
                  opnd_d = mag_2_c;
               end else begin
                  lo_d   = mag_2_c;
                  opnd_d = mag_1_c;
               end
            end
         end
         CALC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (op_q) begin
               if (!div_trial_c[WIDTH]) begin
                  acc_d = div_trial_c[WIDTH-1:0];
                  lo_d  = {lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = div_shift_c[WIDTH-1:0];
                  lo_d  = {lo_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_d = mul_sum_c[WIDTH:1];
               lo_d  = {mul_sum_c[0], lo_q[WIDTH-1:1]};
            end
         end
         FIX: begin
            busy_d = 1'b0;
            done_d = 1'b1;
            if (dz_q) begin
               result_lo_d   = '1;
               result_hi_d   = dividend_c;
               div_by_zero_d = 1'b1;
            end else if (op_q) begin
               result_lo_d   = quo_c;
               result_hi_d   = rem_c;
               div_by_zero_d = 1'b0;
            end else begin
               result_lo_d   = prod_c[WIDTH-1:0];
               result_hi_d   = prod_c[PW-1:WIDTH];
               div_by_zero_d = 1'b0;
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q        <= 1'b0;
         sign_a_q    <= 1'b0;
         sign_b_q    <= 1'b0;
         dz_q        <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         lo_q        <= '0;
         opnd_q      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         result_lo   <= '0;
         result_hi   <= '0;
      end else begin
         op_q        <= op_d;
         sign_a_q    <= sign_a_d;
         sign_b_q    <= sign_b_d;
         dz_q        <= dz_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         lo_q        <= lo_d;
         opnd_q      <= opnd_d;
         busy        <= busy_d;
         done        <= done_d;
         div_by_zero <= div_by_zero_d;
         result_lo   <= result_lo_d;
         result_hi   <= result_hi_d;
      end
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits; iteration count equals WIDTH.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 1 bit: 0 = signed multiply, 1 = signed divide.
REQ-006 SHALL have port data_1, input, WIDTH bits: multiplicand or dividend, two's complement.
REQ-007 SHALL have port data_2, input, WIDTH bits: multiplier or divisor, two's complement; this is the ALU-source operand.
REQ-008 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when results are valid.
REQ-010 SHALL have port result_lo, output, WIDTH bits: product low half or quotient.
REQ-011 SHALL have port result_hi, output, WIDTH bits: product high half or remainder.
REQ-012 SHALL have port div_by_zero, output, 1 bit: the last divide had data_2 == 0.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and FIX.
REQ-014 SHALL, in IDLE with start = 1 at rising edge T, register op and the operand magnitudes, capture the result signs, clear the iteration counter, set busy = 1 and enter CALC.
REQ-015 SHALL ignore data_1, data_2 and op except at the accepting edge T; later changes SHALL NOT affect the result.
REQ-016 SHALL, in CALC, perform one iteration per edge (shift-add for multiply, restoring shift-subtract for divide) over edges T+1..T+WIDTH, then enter FIX.
REQ-017 SHALL, at edge T+WIDTH+1 (T+17 for WIDTH = 16), apply the sign correction, load result_lo and result_hi, set done = 1, clear div_by_zero, set busy = 0 and return to IDLE.
REQ-018 SHALL hold done high for exactly one cycle.
REQ-019 SHALL hold result_lo, result_hi and div_by_zero stable until the next done.
REQ-020 SHALL make multiply return the full 2*WIDTH-bit signed product as {result_hi, result_lo}.
REQ-021 SHALL make divide truncate the quotient toward zero and give the remainder the sign of the dividend (remainder = 0 when exact).
REQ-022 SHALL return, for divide of the most negative value by -1, result_lo = 16'h8000 (wrap) and result_hi = 0, with no error flag.
REQ-023 SHALL, for divide with data_2 == 0 accepted at edge T, skip CALC and at edge T+1 set result_lo = all ones, result_hi = data_1, div_by_zero = 1, done = 1, busy = 0, and return to IDLE.
REQ-024 SHALL ignore start while busy = 1; an ignored start SHALL NOT be queued.
REQ-025 SHALL allow start to be accepted at the edge immediately after the done edge, giving back-to-back operations.
REQ-026 SHALL keep busy = 1 continuously from edge T to the done edge.

Reset
REQ-027 SHALL, while rst = 1, immediately force the FSM to IDLE and drive busy, done, div_by_zero, result_lo and result_hi to 0, independent of clk.
REQ-028 SHALL, on reset asserted mid-operation, abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Verification
REQ-029 SHALL cover mul: data_1 = 16'h0003, data_2 = 16'hFFFE -> done at T+17, result_hi = 16'hFFFF, result_lo = 16'hFFFA.
REQ-030 SHALL cover mul: data_1 = data_2 = 16'h8000 -> result_hi = 16'h4000, result_lo = 16'h0000.
REQ-031 SHALL cover div: data_1 = 16'hFFF9 (-7), data_2 = 16'h0002 -> result_lo = 16'hFFFD, result_hi = 16'hFFFF, div_by_zero = 0.
REQ-032 SHALL cover div: 16'h8000 / 16'hFFFF -> result_lo = 16'h8000, result_hi = 16'h0000; and 16'h1234 / 16'h0000 -> done at T+1, result_lo = 16'hFFFF, result_hi = 16'h1234, div_by_zero = 1.
REQ-033 SHALL cover start pulsed at T+3 during a busy mul: the pulse is ignored, a single done occurs at T+17, and the results match the original operands.
REQ-034 SHALL cover rst asserted between clock edges at T+5: busy = 0 and all outputs = 0 immediately, no done afterwards; a new start after release produces the correct result 17 cycles later.
